branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution stage sitting directly downstream of the branch comparator in the ID stage of the MIPS pipeline. Consumes the comparator's 1-bit result and the branch offset, computes the branch target, and drives PC redirect plus IF/ID flush. Holds the front end with a stall while the hazard unit reports branch operands not yet available. Flags operand waits that exceed a bound.

## Interface
- STALL_LIMIT, 15: maximum consecutive WAIT_OPS cycles before StallTimeout sets.
- CNT_WIDTH, 16: width of the statistics counters.

- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- BranchValid  in  1  ID-stage instruction is a conditional branch.
- OperandsReady  in  1  comparator operands are valid this cycle (forwarded or from the register file).
- CmpResult  in  1  comparator Result; 1 = condition true.
- PCPlus4  in  32  PC of the branch + 4.
- Imm  in  32  sign-extended 16-bit word offset.
- Stall  out  1  hold PC and IF/ID (combinational).
- Flush  out  1  squash the instruction in IF/ID (registered).
- PCSrc  out  1  select BranchTarget as the next PC (registered).
- BranchTarget  out  32  redirect address (registered).
- StallTimeout  out  1  sticky error flag.
- TakenCount  out  CNT_WIDTH  taken-branch count.
- NotTakenCount  out  CNT_WIDTH  not-taken-branch count.

## Operation
- States: IDLE, WAIT_OPS, REDIRECT.
- IDLE:
  - BranchValid=0: remain in IDLE.
  - BranchValid=1, OperandsReady=0: go to WAIT_OPS; Stall=1 this cycle; wait counter cleared to 0.
  - BranchValid=1, OperandsReady=1, CmpResult=1: register BranchTarget = PCPlus4 + {Imm[29:0],2'b00}, computed modulo 2^32 with carry out discarded; go to REDIRECT.
  - BranchValid=1, OperandsReady=1, CmpResult=0: not taken; stay in IDLE. No redirect and no flush.
- WAIT_OPS:
  - Stall = !OperandsReady.
  - On OperandsReady=1, resolve exactly as in IDLE: taken goes to REDIRECT, not taken goes to IDLE.
  - Otherwise the wait counter increments, saturating at STALL_LIMIT.
  - When the counter reaches STALL_LIMIT, StallTimeout sets. It stays set until Reset.
  - The stall continues regardless of StallTimeout.
  - If BranchValid drops while in WAIT_OPS (external flush), return to IDLE with no resolution.
- REDIRECT (exactly one cycle):
  - PCSrc=1, Flush=1, BranchTarget valid.
  - BranchValid is ignored this cycle, because the ID instruction is the one being flushed.
  - Always returns to IDLE.
- There is no delay slot. The instruction fetched after a taken branch is always flushed.
- Back-to-back not-taken branches each resolve in one cycle with no bubble.
- Reset mid-operation: state goes to IDLE. All outputs return to their reset values on the next edge, and any pending redirect is dropped.

## Timing
- Reset values: Stall=0 (state IDLE, stall qualified by state), Flush=0, PCSrc=0, BranchTarget=0, StallTimeout=0, TakenCount=0, NotTakenCount=0.
- Stall is combinational from BranchValid, OperandsReady and state, with zero-cycle latency.
- Taken-branch latency is 1 cycle: resolved at edge N, so PCSrc, Flush and BranchTarget are high/valid during cycle N+1 only.
- PCSrc and Flush are never high for two consecutive cycles.
- Stall and PCSrc are never high in the same cycle.
- BranchTarget holds its last value outside REDIRECT.

## Configuration
- BRANCH_RESOLVE_STATS_EN:
  - Defined: TakenCount increments on each transition into REDIRECT. NotTakenCount increments on each not-taken resolution. Both wrap modulo 2^CNT_WIDTH and both clear on Reset.
  - Undefined: both counter outputs are tied to 0 and no counter registers are synthesized.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset: assert Reset for 2 cycles with BranchValid=1 -> all outputs 0, state IDLE.
- Taken branch, ready:
  - Stimulus: BranchValid=1, OperandsReady=1, CmpResult=1, PCPlus4=0x00000104, Imm=0x00000003.
  - Response: next cycle PCSrc=1, Flush=1, BranchTarget=0x00000110; the following cycle PCSrc=0, Flush=0.
- Backward target and wrap:
  - Imm=0xFFFFFFFE, PCPlus4=0x00000104, taken -> BranchTarget=0x000000FC.
  - PCPlus4=0xFFFFFFFC, Imm=0x00000002, taken -> BranchTarget=0x00000004.
- Operand wait:
  - Stimulus: BranchValid=1, OperandsReady=0 for 3 cycles, then 1 with CmpResult=0.
  - Response: Stall=1 for 3 cycles then 0; PCSrc and Flush never assert; NotTakenCount=1 with the macro defined.
- Timeout: hold OperandsReady=0 for 20 cycles with STALL_LIMIT=15 -> StallTimeout sets after the 15th WAIT_OPS cycle, stays 1, and clears only on Reset.
- Reset mid-redirect: assert Reset in the cycle the taken branch resolves -> PCSrc, Flush and BranchTarget all 0 on the next cycle; TakenCount=0.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch resolution bus: groups the comparator-side inputs and the
// redirect/stall/statistics outputs of the branch_resolve stage.
// The ID stage (or a testbench) connects through the master modport,
// branch_resolve connects through the slave modport.
interface branch_resolve_if #(
  parameter int CNT_WIDTH = 16
);

  logic                 BranchValid;
  logic                 OperandsReady;
  logic                 CmpResult;
  logic [31:0]          PCPlus4;
  logic [31:0]          Imm;
  logic                 Stall;
  logic                 Flush;
  logic                 PCSrc;
  logic [31:0]          BranchTarget;
  logic                 StallTimeout;
  logic [CNT_WIDTH-1:0] TakenCount;
  logic [CNT_WIDTH-1:0] NotTakenCount;

  modport master (
    output BranchValid,
    output OperandsReady,
    output CmpResult,
    output PCPlus4,
    output Imm,
    input  Stall,
    input  Flush,
    input  PCSrc,
    input  BranchTarget,
    input  StallTimeout,
    input  TakenCount,
    input  NotTakenCount
  );

  modport slave (
    input  BranchValid,
    input  OperandsReady,
    input  CmpResult,
    input  PCPlus4,
    input  Imm,
    output Stall,
    output Flush,
    output PCSrc,
    output BranchTarget,
    output StallTimeout,
    output TakenCount,
    output NotTakenCount
  );

endinterface

// File: rtl/branch_resolve.sv
// Branch resolution stage for the MIPS ID stage.
// Takes the comparator result and branch offset, computes the target,
// drives PC redirect and IF/ID flush for one cycle on a taken branch,
// stalls the front end while operands are not ready, and raises a
// sticky StallTimeout when an operand wait runs STALL_LIMIT cycles.
// Optional statistics counters are enabled with BRANCH_RESOLVE_STATS_EN;
// without it TakenCount/NotTakenCount read as 0 and have no registers.
// The CNT_WIDTH parameter must match the CNT_WIDTH of the connected bus.
module branch_resolve #(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  branch_resolve_if.slave bus
);

  localparam int WAIT_W = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPS,
    REDIRECT
  } StateT;

  StateT             r_state;
  StateT             w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitCntNext;
  logic              w_stall;
  logic              w_taken;
  logic              w_notTaken;
  logic              w_setTimeout;
  logic [31:0]       w_target;
  logic              r_pcSrc;
  logic              r_flush;
  logic [31:0]       r_branchTarget;
  logic              r_stallTimeout;
  logic              w_unusedImm;

  // Word offset shifted to bytes; the top two offset bits fall off the
  // end and the add wraps modulo 2^32.
  assign w_target    = bus.PCPlus4 + {bus.Imm[29:0], 2'b00};
  assign w_unusedImm = &{1'b0, bus.Imm[31:30]};

  // Next-state, stall and resolution decode for the resolve FSM.
  always_comb begin
    w_nextState   = r_state;
    w_waitCntNext = r_waitCnt;
    w_stall       = 1'b0;
    w_taken       = 1'b0;
    w_notTaken    = 1'b0;
    w_setTimeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.BranchValid) begin
          if (!bus.OperandsReady) begin
            w_stall       = 1'b1;
            w_nextState   = WAIT_OPS;
            w_waitCntNext = '0;
          end else if (bus.CmpResult) begin
            w_taken     = 1'b1;
            w_nextState = REDIRECT;
          end else begin
            w_notTaken = 1'b1;
          end
        end
      end
      WAIT_OPS: begin
        w_stall = !bus.OperandsReady;
        if (!bus.BranchValid) begin
          w_nextState = IDLE;
        end else if (bus.OperandsReady) begin
          if (bus.CmpResult) begin
            w_taken     = 1'b1;
            w_nextState = REDIRECT;
          end else begin
            w_notTaken  = 1'b1;
            w_nextState = IDLE;
          end
        end else begin
          if (r_waitCnt != WAIT_W'(STALL_LIMIT)) begin
            w_waitCntNext = r_waitCnt + 1'b1;
          end
          if (w_waitCntNext == WAIT_W'(STALL_LIMIT)) begin
            w_setTimeout = 1'b1;
          end
        end
      end
      REDIRECT: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register and operand-wait counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitCntNext;
    end
  end

  // Registered redirect outputs; target holds between taken branches.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pcSrc        <= 1'b0;
      r_flush        <= 1'b0;
      r_branchTarget <= '0;
      r_stallTimeout <= 1'b0;
    end else begin
      r_pcSrc <= w_taken;
      r_flush <= w_taken;
      if (w_taken) begin
        r_branchTarget <= w_target;
      end
      if (w_setTimeout) begin
        r_stallTimeout <= 1'b1;
      end
    end
  end

  assign bus.Stall        = w_stall;
  assign bus.PCSrc        = r_pcSrc;
  assign bus.Flush        = r_flush;
  assign bus.BranchTarget = r_branchTarget;
  assign bus.StallTimeout = r_stallTimeout;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_WIDTH-1:0] r_takenCount;
  logic [CNT_WIDTH-1:0] r_notTakenCount;

  // Wrapping taken / not-taken resolution counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_takenCount    <= '0;
      r_notTakenCount <= '0;
    end else begin
      if (w_taken) begin
        r_takenCount <= r_takenCount + 1'b1;
      end
      if (w_notTaken) begin
        r_notTakenCount <= r_notTakenCount + 1'b1;
      end
    end
  end

  assign bus.TakenCount    = r_takenCount;
  assign bus.NotTakenCount = r_notTakenCount;
`else
  assign bus.TakenCount    = '0;
  assign bus.NotTakenCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking testbench for branch_resolve.
// Expected redirect outputs are queued when a branch is driven and
// popped when the DUT result is sampled one cycle later.
module tb_branch_resolve;

  localparam int CNT_WIDTH   = 16;
  localparam int STALL_LIMIT = 15;

  typedef struct {
    logic        pcSrc;
    logic        flush;
    logic [31:0] target;
  } ExpT;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  int          checks      = 0;
  int          errors      = 0;
  int          expTaken    = 0;
  int          expNotTaken = 0;
  logic [31:0] lastTarget  = 32'h0;
  ExpT         sbQ[$];

  branch_resolve_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  branch_resolve #(
    .STALL_LIMIT(STALL_LIMIT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CNT_WIDTH-1:0] cntModel(input int n);
`ifdef BRANCH_RESOLVE_STATS_EN
    return CNT_WIDTH'(n);
`else
    return '0;
`endif
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic c,
                               input logic [31:0] pc, input logic [31:0] imm);
    bus.BranchValid   = v;
    bus.OperandsReady = r;
    bus.CmpResult     = c;
    bus.PCPlus4       = pc;
    bus.Imm           = imm;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h104, 32'h3);
    Reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.PCSrc !== 1'b0) begin errors++; $display("[TB] FAIL reset_pcsrc: got %0b expected 0", bus.PCSrc); end
    checks++; if (bus.Flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush: got %0b expected 0", bus.Flush); end
    checks++; if (bus.BranchTarget !== 32'h0) begin errors++; $display("[TB] FAIL reset_target: got %h expected 0", bus.BranchTarget); end
    checks++; if (bus.StallTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %0b expected 0", bus.StallTimeout); end
    checks++; if (bus.TakenCount !== '0) begin errors++; $display("[TB] FAIL reset_taken_cnt: got %0d expected 0", bus.TakenCount); end
    checks++; if (bus.NotTakenCount !== '0) begin errors++; $display("[TB] FAIL reset_nottaken_cnt: got %0d expected 0", bus.NotTakenCount); end
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.Stall); end
    Reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_taken(input logic [31:0] pc, input logic [31:0] imm,
                            input logic [31:0] target);
    ExpT e;
    sbQ.push_back('{pcSrc: 1'b1, flush: 1'b1, target: target});
    applyStimulus(1'b1, 1'b1, 1'b1, pc, imm);
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("[TB] FAIL taken_stall: got %0b expected 0", bus.Stall); end
    tick();
    expTaken++;
    lastTarget = target;
    e = sbQ.pop_front();
    checks++; if (bus.PCSrc !== e.pcSrc) begin errors++; $display("[TB] FAIL taken_pcsrc: got %0b expected %0b", bus.PCSrc, e.pcSrc); end
    checks++; if (bus.Flush !== e.flush) begin errors++; $display("[TB] FAIL taken_flush: got %0b expected %0b", bus.Flush, e.flush); end
    checks++; if (bus.BranchTarget !== e.target) begin errors++; $display("[TB] FAIL taken_target: got %h expected %h", bus.BranchTarget, e.target); end
    // During the redirect cycle a new branch waiting on operands is ignored.
    sbQ.push_back('{pcSrc: 1'b0, flush: 1'b0, target: target});
    applyStimulus(1'b1, 1'b0, 1'b1, pc + 32'h4, imm);
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("[TB] FAIL redirect_stall: got %0b expected 0", bus.Stall); end
    tick();
    e = sbQ.pop_front();
    checks++; if (bus.PCSrc !== e.pcSrc) begin errors++; $display("[TB] FAIL after_pcsrc: got %0b expected %0b", bus.PCSrc, e.pcSrc); end
    checks++; if (bus.Flush !== e.flush) begin errors++; $display("[TB] FAIL after_flush: got %0b expected %0b", bus.Flush, e.flush); end
    checks++; if (bus.BranchTarget !== e.target) begin errors++; $display("[TB] FAIL after_target: got %h expected %h", bus.BranchTarget, e.target); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.TakenCount !== cntModel(expTaken)) begin errors++; $display("[TB] FAIL taken_cnt: got %0d expected %0d", bus.TakenCount, cntModel(expTaken)); end
    tick();
  endtask

  task automatic test_back_to_back();
    ExpT e;
    for (int i = 0; i < 4; i++) begin
      sbQ.push_back('{pcSrc: 1'b0, flush: 1'b0, target: lastTarget});
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'h10);
      checks++; if (bus.Stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall[%0d]: got %0b expected 0", i, bus.Stall); end
      tick();
      expNotTaken++;
      e = sbQ.pop_front();
      checks++; if (bus.PCSrc !== e.pcSrc || bus.Flush !== e.flush) begin errors++; $display("[TB] FAIL b2b_redirect[%0d]: got pcsrc=%0b flush=%0b expected 0 0", i, bus.PCSrc, bus.Flush); end
      checks++; if (bus.BranchTarget !== e.target) begin errors++; $display("[TB] FAIL b2b_target[%0d]: got %h expected %h", i, bus.BranchTarget, e.target); end
    end
    checks++; if (bus.NotTakenCount !== cntModel(expNotTaken)) begin errors++; $display("[TB] FAIL b2b_nottaken_cnt: got %0d expected %0d", bus.NotTakenCount, cntModel(expNotTaken)); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_operand_wait();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h500, 32'h8);
      checks++; if (bus.Stall !== 1'b1) begin errors++; $display("[TB] FAIL wait_stall[%0d]: got %0b expected 1", i, bus.Stall); end
      tick();
      checks++; if (bus.PCSrc !== 1'b0 || bus.Flush !== 1'b0) begin errors++; $display("[TB] FAIL wait_redirect[%0d]: got pcsrc=%0b flush=%0b expected 0 0", i, bus.PCSrc, bus.Flush); end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h500, 32'h8);
    checks++; if (bus.Stall !== 1'b0) begin errors++; $display("[TB] FAIL wait_release_stall: got %0b expected 0", bus.Stall); end
    tick();
    expNotTaken++;
    checks++; if (bus.PCSrc !== 1'b0 || bus.Flush !== 1'b0) begin errors++; $display("[TB] FAIL wait_resolve_redirect: got pcsrc=%0b flush=%0b expected 0 0", bus.PCSrc, bus.Flush); end
    checks++; if (bus.StallTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wait_timeout: got %0b expected 0", bus.StallTimeout); end
    checks++; if (bus.NotTakenCount !== cntModel(expNotTaken)) begin errors++; $display("[TB] FAIL wait_nottaken_cnt: got %0d expected %0d", bus.NotTakenCount, cntModel(expNotTaken)); end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    logic expTo;
    // Cycle 1 is the IDLE detection cycle, cycles 2..16 are WAIT_OPS 1..15.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h600, 32'h4);
      checks++; if (bus.Stall !== 1'b1) begin errors++; $display("[TB] FAIL timeout_stall[%0d]: got %0b expected 1", i, bus.Stall); end
      tick();
      expTo = (i >= STALL_LIMIT + 1);
      checks++; if (bus.StallTimeout !== expTo) begin errors++; $display("[TB] FAIL timeout_flag[%0d]: got %0b expected %0b", i, bus.StallTimeout, expTo); end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checks++; if (bus.StallTimeout !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %0b expected 1", bus.StallTimeout); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    expTaken    = 0;
    expNotTaken = 0;
    lastTarget  = 32'h0;
    checks++; if (bus.StallTimeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: got %0b expected 0", bus.StallTimeout); end
    checks++; if (bus.NotTakenCount !== '0 || bus.TakenCount !== '0) begin errors++; $display("[TB] FAIL timeout_cnt_clear: got %0d/%0d expected 0/0", bus.TakenCount, bus.NotTakenCount); end
    tick();
  endtask

  task automatic test_reset_mid_redirect();
    test_taken(32'h200, 32'h1, 32'h204);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h300, 32'h2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    expTaken = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.PCSrc !== 1'b0 || bus.Flush !== 1'b0) begin errors++; $display("[TB] FAIL midrst_redirect: got pcsrc=%0b flush=%0b expected 0 0", bus.PCSrc, bus.Flush); end
    checks++; if (bus.BranchTarget !== 32'h0) begin errors++; $display("[TB] FAIL midrst_target: got %h expected 0", bus.BranchTarget); end
    checks++; if (bus.TakenCount !== '0) begin errors++; $display("[TB] FAIL midrst_taken_cnt: got %0d expected 0", bus.TakenCount); end
    tick();
    checks++; if (bus.PCSrc !== 1'b0) begin errors++; $display("[TB] FAIL midrst_late_pcsrc: got %0b expected 0", bus.PCSrc); end
  endtask

  initial begin
    $display("[TB] starting branch_resolve bench");
    test_reset();
    test_taken(32'h0000_0104, 32'h0000_0003, 32'h0000_0110);
    test_taken(32'h0000_0104, 32'hFFFF_FFFE, 32'h0000_00FC);
    test_taken(32'hFFFF_FFFC, 32'h0000_0002, 32'h0000_0004);
    test_back_to_back();
    test_operand_wait();
    test_timeout();
    test_reset_mid_redirect();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
